// File: rtl/ifu_fetch_queue.sv
// ifu_fetch_queue
//   Instruction fetch unit front end. Issues sequential 4-byte fetch
//   addresses to instruction memory and buffers returned instructions,
//   with their PCs, in a FQ_DEPTH-entry queue toward decode. A redirect
//   flushes the queue. It also arms a drop counter, so that responses
//   still in flight for the old stream are discarded.
//
// Parameters
//   PC_W      width of PC / address signals
//   RESET_PC  first fetch address after reset
//   FQ_DEPTH  queue entries (power of two, >= 2); also max outstanding requests
//
// Ports
//   clk, rst_n                       clock, async active-low reset
//   redirect_valid, redirect_pc      restart fetch at redirect_pc
//   imem_req_valid/ready/addr        request channel (addr 8-byte aligned)
//   imem_rsp_valid, imem_rsp_data    in-order responses, no backpressure
//   inst_valid/ready, inst, inst_pc  queue head toward decode
//
// Optional feature (macro IFU_PERF_EN)
//   perf_req_stall  cycles with no request offered and no redirect
//   perf_redirects  redirect cycles
//   perf_drops      discarded responses
//   All are 32-bit saturating counters.
module ifu_fetch_queue #(
  parameter int unsigned     PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(64'h8000_0000),
  parameter int unsigned     FQ_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [PC_W-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [63:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [PC_W-1:0] inst_pc
`ifdef IFU_PERF_EN
  ,
  output logic [31:0]     perf_req_stall,
  output logic [31:0]     perf_redirects,
  output logic [31:0]     perf_drops
`endif
);

  localparam int unsigned IW = $clog2(FQ_DEPTH);
  // One extra pointer bit distinguishes full from empty.
  localparam int unsigned PW = IW + 1;

  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   fill_q, fill_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [PW-1:0]   drop_q, drop_d;

  logic [PC_W-1:0] pc_q   [FQ_DEPTH];
  logic [31:0]     inst_q [FQ_DEPTH];

  logic [IW-1:0]   head_idx, fill_idx, tail_idx;
  logic [PW-1:0]   alloc_count, unfilled;
  logic            req_fire, rsp_fill, rsp_drop, pop;
  logic            fill_hi;
  logic [31:0]     rsp_word;

  assign head_idx = head_q[IW-1:0];
  assign fill_idx = fill_q[IW-1:0];
  assign tail_idx = tail_q[IW-1:0];

  // Entries in [head, fill) are filled and entries in [fill, tail) await
  // their response, so the per-entry filled flag lives in the pointers.
  assign alloc_count = tail_q - head_q;
  assign unfilled    = tail_q - fill_q;

  // rst_n term keeps the request output low while reset is asserted.
  assign imem_req_valid = rst_n && (alloc_count < PW'(FQ_DEPTH)) &&
                          (drop_q == '0) && !redirect_valid;
  assign imem_req_addr  = imem_req_valid ? {fetch_pc_q[PC_W-1:3], 3'b000} : '0;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_drop = imem_rsp_valid && (drop_q != '0);
  assign rsp_fill = imem_rsp_valid && (drop_q == '0) && !redirect_valid;

  // A zero-latency response targets the entry being allocated this same
  // cycle, whose PC is still only in fetch_pc_q.
  assign fill_hi  = (fill_q == tail_q) ? fetch_pc_q[2] : pc_q[fill_idx][2];
  assign rsp_word = fill_hi ? imem_rsp_data[63:32] : imem_rsp_data[31:0];

  assign inst_valid = (fill_q != head_q);
  assign inst       = inst_valid ? inst_q[head_idx] : '0;
  assign inst_pc    = inst_valid ? pc_q[head_idx]   : '0;
  assign pop        = inst_valid && inst_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    fill_d     = fill_q;
    tail_d     = tail_q;
    drop_d     = drop_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      head_d     = '0;
      fill_d     = '0;
      tail_d     = '0;
      // Everything still in flight after this cycle's response must be
      // discarded: earlier drops plus unfilled entries, less the response
      // consumed now.
      drop_d     = drop_q + unfilled - {{(PW-1){1'b0}}, imem_rsp_valid};
    end else begin
      if (req_fire) begin
        tail_d     = tail_q + PW'(1);
        fetch_pc_d = fetch_pc_q + PC_W'(4);
      end
      if (rsp_fill) fill_d = fill_q + PW'(1);
      if (rsp_drop) drop_d = drop_q - PW'(1);
      if (pop)      head_d = head_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      fill_q     <= '0;
      tail_q     <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      fill_q     <= fill_d;
      tail_q     <= tail_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FQ_DEPTH); i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
    end else begin
      if (req_fire) pc_q[tail_idx]   <= fetch_pc_q;
      if (rsp_fill) inst_q[fill_idx] <= rsp_word;
    end
  end

`ifdef IFU_PERF_EN
  logic [31:0] stall_q, redir_q, drops_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      redir_q <= '0;
      drops_q <= '0;
    end else begin
      if (!imem_req_valid && !redirect_valid && (stall_q != '1))
        stall_q <= stall_q + 32'd1;
      if (redirect_valid && (redir_q != '1))
        redir_q <= redir_q + 32'd1;
      // A response in a redirect cycle is consumed as a drop as well.
      if (imem_rsp_valid && ((drop_q != '0) || redirect_valid) && (drops_q != '1))
        drops_q <= drops_q + 32'd1;
    end
  end

  assign perf_req_stall = stall_q;
  assign perf_redirects = redir_q;
  assign perf_drops     = drops_q;
`endif

endmodule

// File: tb/tb_ifu_fetch_queue.sv
module tb_ifu_fetch_queue;

  localparam int          DEPTH  = 4;
  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [63:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
`ifdef IFU_PERF_EN
  logic [31:0] perf_req_stall, perf_redirects, perf_drops;
`endif

  always #5 clk = ~clk;

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    return {a[31:0] ^ a[63:32] ^ 32'hA5C3_0F96, a[31:0] + 32'h1357_9BDF};
  endfunction

  ifu_fetch_queue #(.PC_W(64), .RESET_PC(64'h8000_0000), .FQ_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc)
`ifdef IFU_PERF_EN
    , .perf_req_stall(perf_req_stall), .perf_redirects(perf_redirects),
    .perf_drops(perf_drops)
`endif
  );

  // Second instance: 32-bit PC starting just below the wrap point,
  // always-ready memory with same-cycle responses, always-ready decode.
  logic        w_req_valid, w_inst_valid;
  logic [31:0] w_req_addr, w_inst, w_inst_pc;
  logic [63:0] w_rsp_data;
`ifdef IFU_PERF_EN
  logic [31:0] w_ps, w_pr, w_pd;
`endif
  assign w_rsp_data = mem_word({32'h0, w_req_addr});

  ifu_fetch_queue #(.PC_W(32), .RESET_PC(32'hFFFF_FFFC), .FQ_DEPTH(2)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1),
    .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_req_valid), .imem_rsp_data(w_rsp_data),
    .inst_valid(w_inst_valid), .inst_ready(1'b1),
    .inst(w_inst), .inst_pc(w_inst_pc)
`ifdef IFU_PERF_EN
    , .perf_req_stall(w_ps), .perf_redirects(w_pr), .perf_drops(w_pd)
`endif
  );

  // ---------------- reference model state ----------------
  typedef struct { logic [63:0] pc; logic [31:0] ins; } exp_t;
  typedef struct { logic [63:0] addr; int ep; int due; } pend_t;

  exp_t        exp_q[$];     // allocated, not yet popped, current stream
  pend_t       pend[$];      // requests memory still owes a response
  int          n_filled;     // leading exp_q entries already filled
  int          epoch;        // bumps on every redirect
  logic [63:0] m_pc;
  bit          m_req_exp;
  bit          active;
  bit          rsp_from_pend;
  int          rsp_epoch;
  int          lat_min, lat_max;
  int          cyc;
  int          n_checks, n_fail;

  logic [31:0] w_addr[2], w_ipc[2], w_ins[2];
  int          w_na, w_ni;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: runs mid-cycle after inputs settle, before the model update.
  always @(negedge clk) begin : mon
    int   n_old;
    exp_t e;
    #3;
    if (active) begin
      n_old = 0;
      foreach (pend[i]) if (pend[i].ep != epoch) n_old++;
      m_req_exp = (exp_q.size() < DEPTH) && (n_old == 0) && !redirect_valid;
      chk("req_valid", 64'(imem_req_valid), 64'(m_req_exp));
      if (m_req_exp && imem_req_ready)
        chk("req_addr", imem_req_addr, m_pc & ~64'h7);
      chk("inst_valid", 64'(inst_valid), 64'(n_filled > 0));
      if (n_filled > 0 && inst_ready && !redirect_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_filled--;
        chk("inst_pc", inst_pc, e.pc);
        chk("inst", 64'(inst), 64'(e.ins));
      end
    end
  end

  always @(negedge clk) begin : mon_w
    #3;
    if (rst_n && w_req_valid && w_na < 2) begin
      w_addr[w_na] = w_req_addr;
      w_na++;
    end
    if (rst_n && w_inst_valid && w_ni < 2) begin
      w_ipc[w_ni] = w_inst_pc;
      w_ins[w_ni] = w_inst;
      w_ni++;
    end
  end

  // One cycle of stimulus: drive inputs, play memory, then update the model.
  task automatic step(input bit redir, input logic [63:0] rpc, input bit rq, input bit ir);
    int          d;
    logic [63:0] w;
    @(negedge clk);
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_req_ready = rq;
    inst_ready     = ir;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    rsp_from_pend  = 1'b0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend[0].addr);
      rsp_epoch      = pend[0].ep;
      rsp_from_pend  = 1'b1;
    end
    #1;
    if (imem_req_valid && imem_req_ready) begin
      d = int'($urandom_range(lat_max, lat_min));
      if (d == 0 && pend.size() == 0 && !imem_rsp_valid) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(imem_req_addr);
        rsp_epoch      = epoch;
      end else begin
        pend.push_back('{addr: imem_req_addr, ep: epoch, due: cyc + ((d == 0) ? 1 : d)});
      end
    end
    #3;
    if (redir) begin
      exp_q.delete();
      n_filled = 0;
      epoch++;
      m_pc = rpc;
    end else begin
      if (m_req_exp && rq) begin
        w = mem_word(m_pc & ~64'h7);
        exp_q.push_back('{pc: m_pc, ins: m_pc[2] ? w[63:32] : w[31:0]});
        m_pc = m_pc + 64'd4;
      end
      if (imem_rsp_valid && rsp_epoch == epoch && n_filled < exp_q.size())
        n_filled++;
    end
    if (rsp_from_pend) void'(pend.pop_front());
    cyc++;
  endtask

  task automatic idle_inputs();
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    inst_ready     = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_req_valid"},  64'(imem_req_valid), 64'd0);
    chk({tag, "_req_addr"},   imem_req_addr,       64'd0);
    chk({tag, "_inst_valid"}, 64'(inst_valid),     64'd0);
    chk({tag, "_inst"},       64'(inst),           64'd0);
    chk({tag, "_inst_pc"},    inst_pc,             64'd0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    pend.delete();
    n_filled = 0;
    m_pc     = RST_PC;
  endtask

  initial begin
    logic [63:0] ww;
    n_checks = 0; n_fail = 0; cyc = 0; epoch = 0;
    w_na = 0; w_ni = 0; active = 1'b0; m_req_exp = 1'b0;
    lat_min = 0; lat_max = 0; rsp_epoch = 0;
    idle_inputs();
    model_reset();
    rst_n = 1'b0;
    #3;
    chk_outputs_zero("reset");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    active = 1'b1;

    // Always-ready memory with same-cycle responses.
    repeat (12) step(1'b0, '0, 1'b1, 1'b1);

    ww = mem_word(64'hFFFF_FFF8);
    chk("wrap_req0", 64'(w_addr[0]), 64'hFFFF_FFF8);
    chk("wrap_req1", 64'(w_addr[1]), 64'h0000_0000);
    chk("wrap_ipc0", 64'(w_ipc[0]),  64'hFFFF_FFFC);
    chk("wrap_ins0", 64'(w_ins[0]),  64'(ww[63:32]));
    ww = mem_word(64'h0);
    chk("wrap_ipc1", 64'(w_ipc[1]),  64'h0);
    chk("wrap_ins1", 64'(w_ins[1]),  64'(ww[31:0]));

    // Decode stalled: queue fills, then a single pop frees one slot.
    repeat (8) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    repeat (4) step(1'b0, '0, 1'b1, 1'b0);
    repeat (8) step(1'b0, '0, 1'b0, 1'b1);

    // Three outstanding requests with 5-cycle latency, then redirect.
    lat_min = 5; lat_max = 5;
    repeat (3) step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, 64'h8000_1004, 1'b1, 1'b1);
    repeat (16) step(1'b0, '0, 1'b1, 1'b1);

    // Redirect coinciding with a response and an inst handshake.
    lat_min = 2; lat_max = 2;
    repeat (10) step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, 64'h8000_2000, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("flush_inst_valid", 64'(inst_valid), 64'd0);
    repeat (10) step(1'b0, '0, 1'b1, 1'b1);

    // Randomised traffic.
    lat_min = 0; lat_max = 4;
    for (int i = 0; i < 1500; i++) begin
      bit r;
      r = ($urandom_range(0, 19) == 0);
      step(r, 64'h8000_0000 + 64'($urandom_range(0, 1023)) * 64'd4,
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end

    // Reset asserted mid-stream with a full queue.
    lat_min = 0; lat_max = 0;
    repeat (8) step(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    active = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    active = 1'b1;
    lat_min = 0; lat_max = 3;
    for (int i = 0; i < 40; i++)
      step(1'b0, '0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0);
    repeat (10) step(1'b0, '0, 1'b0, 1'b1);

    active = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifu_fetch_queue.md
Name: ifu_fetch_queue

Overview:
- Next-generation instruction fetch unit.
- Generates sequential 4-byte fetch addresses from a reset vector and issues them to instruction memory over a valid/ready request channel.
- Accepts in-order responses and buffers fetched instructions, with their PCs, in a parametrised queue toward decode.
- Supports redirects (branch/jump/trap) that flush the queue and discard in-flight responses.

Parameters:
- PC_W, 64: width of all PC/address signals.
- RESET_PC, 64'h8000_0000: first fetch address after reset.
- FQ_DEPTH, 4: fetch queue entries; power of two, >= 2; also the maximum number of outstanding requests.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- redirect_valid  in  1  redirect fetch stream this cycle
- redirect_pc  in  PC_W  new fetch PC; 4-byte aligned
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  PC_W  fetch PC with bits [2:0] cleared
- imem_rsp_valid  in  1  response valid; responses return in request order, no backpressure
- imem_rsp_data  in  64  8-byte aligned memory word
- inst_valid  out  1  queue head holds a filled entry
- inst_ready  in  1  decode consumes the head
- inst  out  32  head instruction
- inst_pc  out  PC_W  head instruction PC

Behaviour:
- Reset (asynchronous, rst_n low):
  - fetch_pc = RESET_PC.
  - Queue empty; alloc/fill/head pointers = 0.
  - drop_cnt = 0.
  - All outputs 0.
- Queue entry fields: pc, inst, filled.
  - Allocated at the tail on request handshake.
  - Filled at the fill pointer on a non-dropped response.
  - Popped at the head on inst handshake.
- Request issue:
  - imem_req_valid = (alloc_count < FQ_DEPTH) && (drop_cnt == 0) && !redirect_valid.
  - redirect_valid gates valid combinationally.
  - Handshake = imem_req_valid && imem_req_ready.
  - On handshake: allocate an entry with pc = fetch_pc, filled = 0; fetch_pc <= fetch_pc + 4 (wraps modulo 2^PC_W).
  - Consecutive PCs in the same 8-byte word issue separate requests.
- Response:
  - If drop_cnt != 0: discard the response; drop_cnt--.
  - Otherwise: write inst = pc[2] ? data[63:32] : data[31:0] into the fill-pointer entry, set filled, advance the fill pointer.
  - A response arriving with no outstanding request is a protocol error; behaviour undefined.
- Output:
  - inst_valid = head entry allocated && filled.
  - inst and inst_pc are driven from the head entry.
  - Pop on inst_valid && inst_ready.
  - Zero-latency bypass is not provided: a response becomes visible as inst_valid the cycle after it arrives.
  - Minimum redirect-to-inst_valid latency is 2 cycles when memory responds in the same cycle as the request.
- Redirect (highest priority):
  - fetch_pc <= redirect_pc.
  - All entries invalidated; pointers reset.
  - drop_cnt <= number of allocated-but-unfilled entries, counted after this cycle's response: a same-cycle response is consumed as a drop.
  - A same-cycle inst handshake is ignored.
- drop_cnt width is log2(FQ_DEPTH)+1. No new requests while drop_cnt != 0, so outstanding requests never exceed FQ_DEPTH.
- Simultaneous events without redirect:
  - Allocate, fill and pop in the same cycle are all legal.
  - Full queue with pop in the same cycle: the request is still blocked that cycle, because alloc_count is evaluated before the pop.
- Mid-operation reset: clears everything immediately. Memory responses from before reset must not arrive after reset deassertion; this is an environment requirement.

Optional Feature:
- Macro IFU_PERF_EN. When defined, three extra outputs, each a 32-bit saturating counter cleared on reset:
  - perf_req_stall: cycles with imem_req_valid=0 and no redirect.
  - perf_redirects: count of redirect cycles.
  - perf_drops: count of discarded responses.
- Undefined: ports and counters absent; core behaviour identical.

Test Plan:
- Reset release, memory always ready, 0-cycle response -> imem_req_addr sequence 0x8000_0000, 0x8000_0000, 0x8000_0008. The inst/inst_pc sequence takes the low half, then the high half, then the low half, with pc 0x8000_0000 / 0x8000_0004 / 0x8000_0008.
- inst_ready=0, FQ_DEPTH=4 -> exactly 4 requests issued, then imem_req_valid=0. Raising inst_ready for 1 cycle -> one pop, and the next request is issued 1 cycle later.
- 3 outstanding requests (responses delayed 5 cycles), redirect to 0x8000_1004 -> drop_cnt=3, no requests until 3 responses are discarded. The first inst out has pc 0x8000_1004 and data[63:32] of word 0x8000_1000.
- Redirect in the same cycle as a response and an inst handshake -> the response is counted as a drop, the queue is empty next cycle, and inst_valid=0.
- fetch_pc = 2^PC_W-4 (PC_W=32, RESET_PC=0xFFFF_FFFC) -> requests 0xFFFF_FFF8, then 0x0000_0000.
- rst_n asserted mid-stream with a full queue -> all outputs 0 asynchronously. After release, the first request address is RESET_PC.
